tile_board_loader: RTL
======================

TILE_BOARD_LOADER -- requirements
Module: tile_board_loader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): EDGE_N, 24, number of edge (track) tiles.
REQ-002 CENTER_N, 12, number of centre (face-down) tiles.
REQ-003 IDX_W, 5, bits per tile picture index.
REQ-004 The block SHALL have one clock and one reset; the reset is asynchronous and active-low. Ports (name, direction, width, meaning):
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 load_start  input  1  single-cycle request to load a new board.
REQ-008 random_edge_order  input  EDGE_N*IDX_W  edge picture indices; slot k occupies bits [IDX_W*k+IDX_W-1 : IDX_W*k].
REQ-009 random_center_order  input  CENTER_N*IDX_W  centre picture indices; slot j uses the same packing.
REQ-010 busy  output  1  high while a load is in progress.
REQ-011 wr_en  output  1  board-memory write strobe.
REQ-012 wr_addr  output  6  board slot address: edge slot k -> k; centre slot j -> EDGE_N+j.
REQ-013 wr_data  output  IDX_W  picture index for wr_addr.
REQ-014 load_done  output  1  one-cycle pulse at the end of every accepted load.
REQ-015 order_error  output  1  high when the last accepted load was rejected.

Function
REQ-016 The FSM SHALL have the states IDLE, CHECK, WRITE and DONE.
REQ-017 In IDLE with load_start=1, the block SHALL capture both order vectors into internal registers, clear order_error and the seen masks, and enter CHECK on the same edge.
REQ-018 load_start SHALL be ignored in every state other than IDLE; the captured vectors SHALL NOT change during a load.
REQ-019 CHECK SHALL last exactly EDGE_N+CENTER_N cycles (36) and examine one slot per cycle, in order: edge 0..23, then centre 0..11.
REQ-020 An edge index >= EDGE_N, a centre index >= CENTER_N, or an index already set in its pool's seen mask SHALL set an internal error flag. Edge and centre pools SHALL use separate masks.
REQ-021 CHECK SHALL always run all 36 cycles and then go to WRITE if the error flag is clear, or to DONE if it is set.
REQ-022 WRITE SHALL last 36 cycles with wr_en=1, wr_addr stepping 0..35 by one per cycle, and wr_data equal to the captured index for that slot.
REQ-023 wr_en SHALL be 0 in every state other than WRITE; a rejected load SHALL produce no writes.
REQ-024 DONE SHALL last one cycle with load_done=1, set order_error=1 if the error flag is set, and then return to IDLE.
REQ-025 busy SHALL be 1 in CHECK, WRITE and DONE, and 0 in IDLE.
REQ-026 Latency for a valid load: if load_start is accepted at edge T, the first write is in the 37th cycle after T, the last write is in the 72nd, load_done is in the 73rd, and busy is low from the 74th.
REQ-027 Latency for a rejected load: load_done and order_error rise in the 37th cycle after T.
REQ-028 The slot counter SHALL be 6 bits wide, SHALL reset to 0 on each state entry, and SHALL NOT wrap within a state.
REQ-029 order_error SHALL hold its value until the next accepted load_start or until reset.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force: state IDLE, busy 0, wr_en 0, wr_addr 0, wr_data 0, load_done 0, order_error 0, counters and seen masks cleared.
REQ-031 Reset asserted mid-load SHALL abort the load with no further writes; after rst_n is released, the block SHALL accept a new load_start in IDLE.

Verification
REQ-032 Identity orders (edge slot k=k, centre slot j=j), load_start at T -> 36 writes at T+37..T+72 with addr 0..35 and data 0..23 then 0..11; load_done at T+73; order_error=0.
REQ-033 Edge slot 5 set to 3 (duplicate of slot 3) -> load_done at T+37, order_error=1, no cycle with wr_en=1.
REQ-034 Centre slot 11 set to 12 (out of range), edge vector valid -> rejected exactly as in REQ-033.
REQ-035 load_start pulsed again at T+10 and T+50 during a valid load -> ignored: exactly 36 writes and one load_done.
REQ-036 rst_n driven low at T+45 (during WRITE) -> wr_en and busy go to 0 immediately with no further writes; after release, an identity load completes normally.
REQ-037 A rejected load followed by a valid load -> order_error clears on the edge that accepts the second load_start and stays 0 through its load_done.

Source files
------------

// File: rtl/tile_board_loader.sv
// Board loader: captures edge/centre picture orders, checks they are permutations,
// then streams them into board memory (edge slots first, centre slots after).
module tile_board_loader #(
  parameter int EDGE_N   = 24,
  parameter int CENTER_N = 12,
  parameter int IDX_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  input  logic [EDGE_N*IDX_W-1:0]   random_edge_order,
  input  logic [CENTER_N*IDX_W-1:0] random_center_order,
  output logic                      busy,
  output logic                      wr_en,
  output logic [5:0]                wr_addr,
  output logic [IDX_W-1:0]          wr_data,
  output logic                      load_done,
  output logic                      order_error
);

  localparam int         SLOTS    = EDGE_N + CENTER_N;
  localparam logic [5:0] LAST     = 6'(SLOTS - 1);
  localparam logic [5:0] EDGE_END = 6'(EDGE_N);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  state_t                          state, state_nxt;
  logic [SLOTS-1:0][IDX_W-1:0]     slot_q;
  logic [5:0]                      cnt;
  logic [EDGE_N-1:0]               edge_seen;
  logic [CENTER_N-1:0]             center_seen;
  logic                            err_q, err_nxt, slot_bad, is_edge;
  logic [IDX_W-1:0]                cur_idx;

  // Edge slots sit in the low half of slot_q so slot number == board address.
  assign cur_idx = slot_q[cnt];
  assign is_edge = cnt < EDGE_END;

  always_comb begin
    slot_bad = 1'b0;
    if (is_edge) begin
      if (32'(cur_idx) >= EDGE_N) slot_bad = 1'b1;
      for (int i = 0; i < EDGE_N; i++)
        if (32'(cur_idx) == i && edge_seen[i]) slot_bad = 1'b1;
    end else begin
      if (32'(cur_idx) >= CENTER_N) slot_bad = 1'b1;
      for (int i = 0; i < CENTER_N; i++)
        if (32'(cur_idx) == i && center_seen[i]) slot_bad = 1'b1;
    end
    err_nxt = err_q | slot_bad;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load_start) state_nxt = CHECK;
      CHECK: if (cnt == LAST) state_nxt = err_nxt ? DONE : WRITE;
      WRITE: if (cnt == LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      slot_q      <= '0;
      edge_seen   <= '0;
      center_seen <= '0;
      err_q       <= 1'b0;
      order_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                    cnt <= '0;
      else if (state == CHECK || state == WRITE) cnt <= cnt + 6'd1;
      case (state)
        IDLE: if (load_start) begin
          slot_q      <= {random_center_order, random_edge_order};
          edge_seen   <= '0;
          center_seen <= '0;
          err_q       <= 1'b0;
          order_error <= 1'b0;
        end
        CHECK: begin
          err_q <= err_nxt;
          // Out-of-range indices match no bit, so they never mark a mask.
          if (is_edge) begin
            for (int i = 0; i < EDGE_N; i++)
              if (32'(cur_idx) == i) edge_seen[i] <= 1'b1;
          end else begin
            for (int i = 0; i < CENTER_N; i++)
              if (32'(cur_idx) == i) center_seen[i] <= 1'b1;
          end
          // Raised on entry to DONE so it is visible alongside load_done.
          if (cnt == LAST) order_error <= err_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign wr_en     = (state == WRITE);
  assign wr_addr   = wr_en ? cnt : 6'd0;
  assign wr_data   = wr_en ? cur_idx : '0;
  assign load_done = (state == DONE);

endmodule
